// File: rtl/ramb4_pkg.sv
// Shared types and sizes for the RAMB4_S4 arbiter slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: RAM geometry constants, the registered RAM command record and the
// clear state encoding used when RAMB4_S4_ARBITER_CLEAR_EN is defined.
package ramb4_pkg;

  localparam int RAMB4_S4_ADDR_W = 10;
  localparam int RAMB4_S4_DATA_W = 4;
  localparam int RAMB4_S4_DEPTH  = 1024;

  // One command as presented on the RAM port.
  typedef struct packed {
    logic                       we;
    logic [RAMB4_S4_ADDR_W-1:0] addr;
    logic [RAMB4_S4_DATA_W-1:0] di;
  } ram_cmd_t;

  // Clear sequencer state, kept as plain constants for legacy tools.
  typedef logic [0:0] clr_state_t;
  localparam clr_state_t CLR_IDLE = 1'b0;
  localparam clr_state_t CLR_RUN  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant with a round-robin pointer, or fixed priority to requester 0.
// Latency: grant is combinational from valid0/valid1, en and the pointer.
// Backpressure: en=0 withholds both grants; the pointer only moves on a grant.
//
// Ports:
//   CLK, RST_N      clock, asynchronous active-low reset
//   en              grants allowed this cycle
//   valid0, valid1  requests
//   gnt0, gnt1      one-hot (or zero) grants; grant == acceptance
module rr_arb2 #(
  parameter int PRIO_FIXED = 0
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic gnt0,
  output logic gnt1
);

  // ptr = 0: requester 0 wins a tie; ptr = 1: requester 1 wins a tie.
  logic ptr;
  logic pick1;

  always_comb begin
    if (PRIO_FIXED != 0) begin
      pick1 = !valid0;
    end else begin
      pick1 = valid1 && (!valid0 || ptr);
    end
  end

  assign gnt0 = en && valid0 && !pick1;
  assign gnt1 = en && valid1 && pick1;

  // Hand priority to whoever did not just win.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr <= 1'b0;
    end else if (gnt0) begin
      ptr <= 1'b1;
    end else if (gnt1) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/ramb4_s4_arbiter.sv
// Two-requester arbiter/sequencer in front of a 1024x4 write-first block RAM.
// Latency: accept edge to RSPx_VALID = 2 edges; one command per cycle.
// Backpressure: REQx_READY only from arbitration/clear; responses cannot stall.
//
// Ports:
//   CLK, RST_N                      clock, asynchronous active-low reset
//   REQx_VALID/READY/WE/ADDR/DI     requester x command (x = 0, 1)
//   RSPx_VALID/DO                   response to requester x (DO = RAM_DO)
//   RAM_EN/WE/RST/ADDR/DI, RAM_DO   RAM primitive port (RAM_RST tied 0)
//   CLR_START, CLR_BUSY             only with RAMB4_S4_ARBITER_CLEAR_EN:
//                                   zero-fill of the whole RAM, run at reset
//                                   and on a CLR_START pulse while idle.
// ADDR_W and DATA_W must stay at the RAM geometry (10 / 4).
module ramb4_s4_arbiter
  import ramb4_pkg::*;
#(
  parameter int PRIO_FIXED = 0,
  parameter int ADDR_W     = RAMB4_S4_ADDR_W,
  parameter int DATA_W     = RAMB4_S4_DATA_W
) (
`ifdef RAMB4_S4_ARBITER_CLEAR_EN
  input  logic              CLR_START,
  output logic              CLR_BUSY,
`endif
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ0_VALID,
  output logic              REQ0_READY,
  input  logic              REQ0_WE,
  input  logic [ADDR_W-1:0] REQ0_ADDR,
  input  logic [DATA_W-1:0] REQ0_DI,
  output logic              RSP0_VALID,
  output logic [DATA_W-1:0] RSP0_DO,
  input  logic              REQ1_VALID,
  output logic              REQ1_READY,
  input  logic              REQ1_WE,
  input  logic [ADDR_W-1:0] REQ1_ADDR,
  input  logic [DATA_W-1:0] REQ1_DI,
  output logic              RSP1_VALID,
  output logic [DATA_W-1:0] RSP1_DO,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic              RAM_RST,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_DI,
  input  logic [DATA_W-1:0] RAM_DO
);

  logic              clr_run;
  logic [ADDR_W-1:0] clr_addr;

`ifdef RAMB4_S4_ARBITER_CLEAR_EN
  clr_state_t        clr_state;
  logic [ADDR_W-1:0] clr_cnt;

  assign clr_run  = (clr_state == CLR_RUN);
  assign clr_addr = clr_cnt;
  assign CLR_BUSY = clr_run;

  // One zero write per cycle; the all-ones address is the last one.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clr_state <= CLR_RUN;
      clr_cnt   <= '0;
    end else begin
      case (clr_state)
        CLR_RUN: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (&clr_cnt) begin
            clr_state <= CLR_IDLE;
          end
        end
        default: begin
          if (CLR_START) begin
            clr_state <= CLR_RUN;
            clr_cnt   <= '0;
          end
        end
      endcase
    end
  end
`else
  assign clr_run  = 1'b0;
  assign clr_addr = '0;
`endif

  logic arb_en;
  assign arb_en = !clr_run;

  rr_arb2 #(
    .PRIO_FIXED (PRIO_FIXED)
  ) u_arb (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .en     (arb_en),
    .valid0 (REQ0_VALID),
    .valid1 (REQ1_VALID),
    .gnt0   (REQ0_READY),
    .gnt1   (REQ1_READY)
  );

  logic     accept;
  ram_cmd_t win_cmd;
  ram_cmd_t cmd_q;
  ram_cmd_t cmd_nxt;
  logic     en_q;
  logic     en_nxt;

  assign accept = REQ0_READY || REQ1_READY;

  always_comb begin
    if (REQ1_READY) begin
      win_cmd = '{we: REQ1_WE, addr: REQ1_ADDR, di: REQ1_DI};
    end else begin
      win_cmd = '{we: REQ0_WE, addr: REQ0_ADDR, di: REQ0_DI};
    end
  end

  // Idle cycles drop EN/WE but leave address and data where they were.
  always_comb begin
    en_nxt     = 1'b0;
    cmd_nxt    = cmd_q;
    cmd_nxt.we = 1'b0;
    if (clr_run) begin
      en_nxt  = 1'b1;
      cmd_nxt = '{we: 1'b1, addr: clr_addr, di: '0};
    end else if (accept) begin
      en_nxt  = 1'b1;
      cmd_nxt = win_cmd;
    end
  end

  // Tag pipeline: stage 1 lines up with the command on the RAM port,
  // stage 2 with RAM_DO. Clear writes never enter it.
  logic s1_vld, s1_tag;
  logic s2_vld, s2_tag;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      en_q   <= 1'b0;
      cmd_q  <= '0;
      s1_vld <= 1'b0;
      s1_tag <= 1'b0;
      s2_vld <= 1'b0;
      s2_tag <= 1'b0;
    end else begin
      en_q   <= en_nxt;
      cmd_q  <= cmd_nxt;
      s1_vld <= accept;
      s1_tag <= REQ1_READY;
      s2_vld <= s1_vld;
      s2_tag <= s1_tag;
    end
  end

  assign RAM_EN   = en_q;
  assign RAM_WE   = cmd_q.we;
  assign RAM_RST  = 1'b0;
  assign RAM_ADDR = cmd_q.addr;
  assign RAM_DI   = cmd_q.di;

  assign RSP0_VALID = s2_vld && !s2_tag;
  assign RSP1_VALID = s2_vld && s2_tag;
  assign RSP0_DO    = RAM_DO;
  assign RSP1_DO    = RAM_DO;

endmodule

// File: tb/tb_ramb4_s4_arbiter.sv
// Bench for ramb4_s4_arbiter: round-robin instance with a write-first RAM
// model and scoreboard, plus a PRIO_FIXED=1 instance sharing the requests.
module tb_ramb4_s4_arbiter;
  import ramb4_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST_N;
  logic v0, we0, v1, we1;
  logic [9:0] a0, a1;
  logic [3:0] d0, d1;

  logic r0, r1, rv0, rv1;
  logic [3:0] rd0, rd1;
  logic ram_en, ram_we, ram_rst;
  logic [9:0] ram_addr;
  logic [3:0] ram_di;
  logic [3:0] ram_do = 4'h0;

  logic pr0, pr1, prv0, prv1, p_en, p_we, p_rst;
  logic [9:0] p_addr;
  logic [3:0] prd0, prd1, p_di;
  logic [3:0] p_do = 4'h0;
  logic unused_p;
  assign unused_p = ^{prd0, prd1, p_en, p_we, p_addr, p_di, p_rst, prv0, prv1, p_do};

  logic clr_start = 1'b0;
  logic clr_busy, p_clr_busy;

  ramb4_s4_arbiter #(.PRIO_FIXED(0)) dut (
`ifdef RAMB4_S4_ARBITER_CLEAR_EN
    .CLR_START(clr_start), .CLR_BUSY(clr_busy),
`endif
    .CLK(CLK), .RST_N(RST_N),
    .REQ0_VALID(v0), .REQ0_READY(r0), .REQ0_WE(we0), .REQ0_ADDR(a0), .REQ0_DI(d0),
    .RSP0_VALID(rv0), .RSP0_DO(rd0),
    .REQ1_VALID(v1), .REQ1_READY(r1), .REQ1_WE(we1), .REQ1_ADDR(a1), .REQ1_DI(d1),
    .RSP1_VALID(rv1), .RSP1_DO(rd1),
    .RAM_EN(ram_en), .RAM_WE(ram_we), .RAM_RST(ram_rst), .RAM_ADDR(ram_addr),
    .RAM_DI(ram_di), .RAM_DO(ram_do)
  );

  ramb4_s4_arbiter #(.PRIO_FIXED(1)) dut_p (
`ifdef RAMB4_S4_ARBITER_CLEAR_EN
    .CLR_START(clr_start), .CLR_BUSY(p_clr_busy),
`endif
    .CLK(CLK), .RST_N(RST_N),
    .REQ0_VALID(v0), .REQ0_READY(pr0), .REQ0_WE(we0), .REQ0_ADDR(a0), .REQ0_DI(d0),
    .RSP0_VALID(prv0), .RSP0_DO(prd0),
    .REQ1_VALID(v1), .REQ1_READY(pr1), .REQ1_WE(we1), .REQ1_ADDR(a1), .REQ1_DI(d1),
    .RSP1_VALID(prv1), .RSP1_DO(prd1),
    .RAM_EN(p_en), .RAM_WE(p_we), .RAM_RST(p_rst), .RAM_ADDR(p_addr),
    .RAM_DI(p_di), .RAM_DO(p_do)
  );

  // Write-first synchronous RAM; contents survive reset.
`ifdef RAMB4_S4_ARBITER_CLEAR_EN
  localparam logic [3:0] MEM_INIT = 4'h9;
`else
  localparam logic [3:0] MEM_INIT = 4'h0;
`endif
  logic [3:0] mem [0:1023];
  logic mem_rdy = 1'b0;
  always @(posedge CLK) begin
    if (!mem_rdy) begin
      for (int i = 0; i < 1024; i++) mem[i] <= MEM_INIT;
      mem_rdy <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_di;
        ram_do <= ram_di;
      end else begin
        ram_do <= mem[ram_addr];
      end
    end
  end

  typedef struct {
    logic who;
    logic [3:0] dat;
    int cyc;
  } exp_t;
  exp_t sbq[$];
  logic [3:0] ref_mem [0:1023];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Values sampled at the falling edge of each step.
  logic en_s, we_s, pr0_s, pr1_s, busy_s;
  logic [9:0] addr_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic iv0, input logic iwe0, input logic [9:0] ia0,
                      input logic [3:0] id0, input logic iv1, input logic iwe1,
                      input logic [9:0] ia1, input logic [3:0] id1,
                      output logic g0, output logic g1);
    exp_t e;
    v0 = iv0; we0 = iwe0; a0 = ia0; d0 = id0;
    v1 = iv1; we1 = iwe1; a1 = ia1; d1 = id1;
    @(negedge CLK);
    g0 = r0; g1 = r1;
    en_s = ram_en; we_s = ram_we; addr_s = ram_addr;
    pr0_s = pr0; pr1_s = pr1;
`ifdef RAMB4_S4_ARBITER_CLEAR_EN
    busy_s = clr_busy;
`else
    busy_s = 1'b0;
`endif
    chk("ready_onehot", 32'(r0 & r1), 32'd0);
    chk("rsp_onehot", 32'(rv0 & rv1), 32'd0);
    if (rv0 || rv1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual rv0=%0b rv1=%0b required none", rv0, rv1);
      end else begin
        e = sbq.pop_front();
        chk("rsp_who", 32'(rv1), 32'(e.who));
        chk("rsp_do", 32'(rv1 ? rd1 : rd0), 32'(e.dat));
        chk("rsp_latency", 32'(cyc - e.cyc), 32'd2);
      end
    end
    if (g0 || g1) begin
      e.who = g1;
      e.cyc = cyc;
      if (g1 ? iwe1 : iwe0) begin
        e.dat = g1 ? id1 : id0;
        ref_mem[g1 ? ia1 : ia0] = e.dat;
      end else begin
        e.dat = ref_mem[g1 ? ia1 : ia0];
      end
      sbq.push_back(e);
    end
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    logic g0, g1;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
  endtask

  // Holds reset low for two edges and checks reset values while low.
  task automatic do_reset();
    v0 = 0; we0 = 0; a0 = 0; d0 = 0;
    v1 = 0; we1 = 0; a1 = 0; d1 = 0;
    RST_N = 1'b0;
    sbq.delete();
    @(negedge CLK);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_di", 32'(ram_di), 32'd0);
    chk("rst_rsp", 32'({rv0, rv1}), 32'd0);
    chk("rst_ready", 32'({r0, r1}), 32'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  typedef struct {
    logic v0, we0; logic [9:0] a0; logic [3:0] d0;
    logic v1, we1; logic [9:0] a1; logic [3:0] d1;
    logic er0, er1;
    logic c_ram, e_en, e_we; logic [9:0] e_addr;
  } vec_t;
  vec_t tbl [15];

  initial begin
    logic g0, g1;
    int n;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 4'h0;

    //          v0    we0   a0      d0    v1    we1   a1      d1    er0   er1   c_ram e_en  e_we  e_addr
    tbl[0]  = '{1'b1, 1'b1, 10'h3FF, 4'hA, 1'b0, 1'b0, 10'h000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
    tbl[1]  = '{1'b0, 1'b0, 10'h000, 4'h0, 1'b0, 1'b0, 10'h000, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'h3FF};
    tbl[2]  = '{1'b0, 1'b0, 10'h000, 4'h0, 1'b0, 1'b0, 10'h000, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h3FF};
    tbl[3]  = '{1'b0, 1'b0, 10'h000, 4'h0, 1'b1, 1'b0, 10'h3FF, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000};
    tbl[4]  = '{1'b1, 1'b1, 10'h005, 4'h3, 1'b1, 1'b1, 10'h006, 4'hC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h3FF};
    tbl[5]  = '{1'b0, 1'b0, 10'h000, 4'h0, 1'b1, 1'b1, 10'h006, 4'hC, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 10'h005};
    tbl[6]  = '{1'b1, 1'b0, 10'h005, 4'h0, 1'b1, 1'b0, 10'h006, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 10'h006};
    tbl[7]  = '{1'b1, 1'b0, 10'h005, 4'h0, 1'b1, 1'b0, 10'h006, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'h005};
    tbl[8]  = '{1'b1, 1'b0, 10'h005, 4'h0, 1'b1, 1'b0, 10'h006, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h006};
    tbl[9]  = '{1'b1, 1'b0, 10'h005, 4'h0, 1'b1, 1'b0, 10'h006, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000};
    tbl[10] = '{1'b1, 1'b1, 10'h010, 4'h5, 1'b0, 1'b0, 10'h000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
    tbl[11] = '{1'b1, 1'b0, 10'h010, 4'h0, 1'b0, 1'b0, 10'h000, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 10'h010};
    tbl[12] = '{1'b0, 1'b0, 10'h000, 4'h0, 1'b0, 1'b0, 10'h000, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h010};
    tbl[13] = '{1'b0, 1'b0, 10'h000, 4'h0, 1'b0, 1'b0, 10'h000, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h010};
    tbl[14] = '{1'b0, 1'b0, 10'h000, 4'h0, 1'b0, 1'b0, 10'h000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000};

    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    do_reset();

`ifdef RAMB4_S4_ARBITER_CLEAR_EN
    // Clear runs straight out of reset; READY0 must stay low 1024 cycles.
    n = 0;
    g0 = 1'b0;
    for (int i = 0; i < 3000 && !g0; i++) begin
      step(1, 0, 10'h2A7, 0, 0, 0, 0, 0, g0, g1);
      chk("clr_busy", 32'(busy_s), 32'(!g0));
      if (!g0) n++;
    end
    chk("clr_cycles", 32'(n), 32'd1024);
    idle(3);
`endif

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].v0, tbl[i].we0, tbl[i].a0, tbl[i].d0,
           tbl[i].v1, tbl[i].we1, tbl[i].a1, tbl[i].d1, g0, g1);
      chk($sformatf("vec%0d_ready0", i), 32'(g0), 32'(tbl[i].er0));
      chk($sformatf("vec%0d_ready1", i), 32'(g1), 32'(tbl[i].er1));
      if (tbl[i].c_ram) begin
        chk($sformatf("vec%0d_ram_en", i), 32'(en_s), 32'(tbl[i].e_en));
        if (tbl[i].e_en) chk($sformatf("vec%0d_ram_we", i), 32'(we_s), 32'(tbl[i].e_we));
        chk($sformatf("vec%0d_ram_addr", i), 32'(addr_s), 32'(tbl[i].e_addr));
      end
    end

    // Fixed-priority instance: requester 1 starves until requester 0 drops.
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 10'h005, 0, 1, 0, 10'h006, 0, g0, g1);
      chk("prio_ready0", 32'(pr0_s), 32'd1);
      chk("prio_ready1", 32'(pr1_s), 32'd0);
    end
    step(0, 0, 0, 0, 1, 0, 10'h006, 0, g0, g1);
    chk("prio_ready1_after", 32'(pr1_s), 32'd1);
    idle(3);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    chk("ram_rst_tied", 32'(ram_rst), 32'd0);

    // Reset one cycle after an accept: the in-flight read must vanish.
    step(1, 0, 10'h3FF, 0, 0, 0, 0, 0, g0, g1);
    chk("pre_rst_accept", 32'(g0), 32'd1);
    do_reset();
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ramb4_s4_arbiter.md
Name: ramb4_s4_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for one 1024x4 single-port block RAM (synchronous read, write-first output).
- Sits between two client engines and the RAM primitive.
- Registers one command per cycle onto the RAM port and returns read data, or write-through data, to the issuing requester with fixed latency.

Parameters:
- PRIO_FIXED, 0, 0 = round-robin between requesters; 1 = requester 0 always wins.
- ADDR_W, 10, address width; fixed to the RAM depth; any other value is illegal.
- DATA_W, 4, data width; fixed to the RAM width.

Ports:
- CLK  in  1  single clock; all state updates on rising edge
- RST_N  in  1  asynchronous active-low reset
- REQ0_VALID  in  1  requester 0 command valid
- REQ0_READY  out  1  requester 0 command accepted this cycle
- REQ0_WE  in  1  1 = write, 0 = read
- REQ0_ADDR  in  ADDR_W  command address
- REQ0_DI  in  DATA_W  write data
- RSP0_VALID  out  1  response for requester 0
- RSP0_DO  out  DATA_W  response data
- REQ1_VALID, REQ1_READY, REQ1_WE, REQ1_ADDR, REQ1_DI, RSP1_VALID, RSP1_DO: same for requester 1
- RAM_EN  out  1  RAM enable
- RAM_WE  out  1  RAM write enable
- RAM_RST  out  1  RAM output reset; constant 0
- RAM_ADDR  out  ADDR_W  RAM address
- RAM_DI  out  DATA_W  RAM write data
- RAM_DO  in  DATA_W  RAM registered output

Behaviour:
- Reset values (async on RST_N low):
  - RAM_EN, RAM_WE, RAM_ADDR, RAM_DI = 0.
  - RSPx_VALID = 0.
  - Round-robin pointer = requester 0 has priority.
  - Response tag pipeline cleared.
- REQx_READY is combinational from VALIDs, the pointer and the clear FSM. It never depends on RSP state.
- At most one READY is high per cycle. Acceptance = VALID & READY.
- Arbitration:
  - Only one VALID high: that requester gets READY.
  - Both VALID high: the pointer holder wins.
  - Round-robin: after every accepted command the pointer moves to the non-winner.
  - PRIO_FIXED=1: requester 0 always wins and the pointer is ignored.
- Cycle t (accept edge E1): RAM_EN=1, RAM_WE=REQx_WE, RAM_ADDR and RAM_DI registered from the winner. A 1-bit tag for the winner is captured in stage 1.
- Idle cycle: RAM_EN registered 0. RAM_ADDR and RAM_DI hold their previous values.
- Edge E2: RAM samples the command and RAM_DO updates. The tag advances to stage 2.
- Cycle after E2: RSPy_VALID=1 for the tagged requester only, with RSPy_DO = RAM_DO passed through combinationally.
- Latency: accept edge to RSP_VALID high = 2 edges. Throughput = 1 command per cycle. No response backpressure; clients must always sink responses.
- Writes also produce a response. RSP_DO = the written data, per write-first behaviour.
- RSPx_DO value is don't-care when RSPx_VALID=0. The bench must not check it then.
- Back-to-back write then read to the same address on consecutive cycles: the read returns the new data. No hazard logic is needed.
- RST_N asserted mid-operation: in-flight tags are discarded. No response is emitted for commands accepted before reset. RAM contents are untouched.
- No address wrap-around logic: ADDR is used unmodified. Address 1023 is legal.

Optional Feature:
- Macro: RAMB4_S4_ARBITER_CLEAR_EN.
- Defined, ports added:
  - CLR_START (in, 1): a pulse in idle state starts a clear.
  - CLR_BUSY (out, 1; reset value 1).
- Defined, state machine: CLR_IDLE / CLR_RUN.
  - Reset enters CLR_RUN with counter = 0.
  - CLR_RUN: each cycle issue RAM write of 0 to counter address and increment the counter.
  - After the write to 1023, return to CLR_IDLE. This takes exactly 1024 cycles.
  - CLR_RUN forces both READY=0. Clear writes generate no responses.
  - CLR_START while already in CLR_RUN is ignored.
  - Clear writes already in the RAM pipeline complete normally.
- Undefined: ports absent. No clear FSM. Arbiter is in service from the first cycle after reset.

Decomposition:
- Shared package ramb4_pkg:
  - RAMB4_S4_ADDR_W=10, RAMB4_S4_DATA_W=4, RAMB4_S4_DEPTH=1024.
  - Typedef ram_cmd_t {we, addr, di}.
  - Typedef clr_state_t.
- One natural sub-module: rr_arb2, a 2-way round-robin grant with pointer and PRIO_FIXED.
- Pipeline and clear FSM stay in the top module.

Test Plan:
- Only REQ0 writes addr 0x3FF data 0xA: READY0=1 same cycle; RAM_EN=RAM_WE=1, RAM_ADDR=0x3FF next cycle; RSP0_VALID with DO=0xA 2 edges after accept; later read of 0x3FF returns 0xA.
- Both VALID every cycle (REQ0 reads addr 5, REQ1 reads addr 6): grants alternate 0,1,0,1; RSP0 and RSP1 alternate with the matching data; never both VALID in one cycle.
- PRIO_FIXED=1, both VALID for 4 cycles: REQ1_READY stays 0 throughout; REQ1 is granted the cycle after REQ0_VALID drops.
- Write 0x5 then read, same addr 0x010, consecutive cycles: two responses on consecutive cycles, both DO=0x5.
- RST_N pulled low one cycle after an accept: no RSP_VALID afterwards; all outputs at reset values while RST_N is low.
- With RAMB4_S4_ARBITER_CLEAR_EN: after reset, READYs stay 0 for 1024 cycles and CLR_BUSY falls; a read of any address (e.g. 0x2A7) then returns 0x0.
